wave_seq_ctrl: RTL and testbench

//  Sequencer for the DDS waveform generator driving the 12-bit DAC. Holds a small

---
 rtl/wave_seq_ctrl.sv | 98 +++++++++
 tb/tb_wave_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: DDS segment sequencer with DAC tick pacing; WSEQ_IRQ_EN adds a sticky done irq
module wave_seq_ctrl #(
  parameter int FTW_W = 16,
  parameter int DUR_W = 24,
  parameter int ADDR_W = 3,
  parameter int TICK_DIV = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [FTW_W-1:0]  cfg_ftw,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic              cfg_last,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [FTW_W-1:0]  ftw_out,
  output logic              ftw_valid,
  input  logic              ftw_ready,
  output logic              gen_en,
  output logic              dac_tick,
  output logic [ADDR_W-1:0] seg_idx,
  output logic              busy,
  output logic              done
`ifdef WSEQ_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] idx_d;
  logic [TW-1:0] tick_cnt;
  logic [DUR_W-1:0] dur_cnt, seg_dur;
  logic seg_last, seg_end, wrap;
  logic [FTW_W-1:0] tbl_ftw [DEPTH];
  logic [DUR_W-1:0] tbl_dur [DEPTH];
  logic tbl_last [DEPTH];
  always_ff @(posedge clk) tick_cnt <= (reset || dac_tick) ? '0 : tick_cnt + 1'b1;
  assign dac_tick = tick_cnt == TW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (cfg_we) begin
      tbl_ftw[cfg_addr] <= cfg_ftw;
      tbl_dur[cfg_addr] <= cfg_dur;
      tbl_last[cfg_addr] <= cfg_last;
    end
  assign seg_end = dac_tick && dur_cnt == DUR_W'(1);
  assign wrap = seg_last || &seg_idx;
  always_comb begin
    state_d = state;
    idx_d = seg_idx;
    case (state)
      IDLE: if (start && !stop) begin
        state_d = LOAD;
        idx_d = '0;
      end
      LOAD: state_d = stop ? IDLE : ftw_ready ? RUN : LOAD;
      RUN:
        if (stop) state_d = IDLE;
        else if (seg_end) begin
          state_d = (wrap && !loop_en) ? FINISH : LOAD;
          idx_d = wrap ? (loop_en ? '0 : seg_idx) : seg_idx + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  // entry fields are snapshotted on entering LOAD so later table writes hit only the next load
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      seg_idx <= '0;
      ftw_out <= '0;
      seg_dur <= '0;
      seg_last <= 1'b0;
      dur_cnt <= '0;
    end else begin
      state <= state_d;
      seg_idx <= idx_d;
      if (state_d == LOAD && state != LOAD) begin
        ftw_out <= tbl_ftw[idx_d];
        seg_dur <= tbl_dur[idx_d];
        seg_last <= tbl_last[idx_d];
      end
      if (state == LOAD && ftw_ready) dur_cnt <= (seg_dur == '0) ? DUR_W'(1) : seg_dur;
      else if (state == RUN && dac_tick) dur_cnt <= dur_cnt - 1'b1;
    end
  assign ftw_valid = state == LOAD;
  assign gen_en = state == RUN;
  assign busy = state == LOAD || state == RUN;
  assign done = state == FINISH;
`ifdef WSEQ_IRQ_EN
  always_ff @(posedge clk) irq <= reset ? 1'b0 : done ? 1'b1 : irq_clr ? 1'b0 : irq;
`endif
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl: directed program runs checked against a segment-level model every cycle
module tb_wave_seq_ctrl;
  localparam int FTW_W = 16, DUR_W = 24, ADDR_W = 3, TICK = 18, DEPTH = 8;
  logic clk = 0, reset = 1, cfg_we = 0, cfg_last = 0, start = 0, stop = 0, loop_en = 0, ftw_ready = 0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [FTW_W-1:0] cfg_ftw = '0;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic [FTW_W-1:0] ftw_out;
  logic ftw_valid, gen_en, dac_tick, busy, done;
  logic [ADDR_W-1:0] seg_idx;
`ifdef WSEQ_IRQ_EN
  logic irq, irq_clr = 0;
  bit m_irq, clr_on_done = 0;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wave_seq_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_ftw(cfg_ftw),
    .cfg_dur(cfg_dur), .cfg_last(cfg_last), .start(start), .stop(stop), .loop_en(loop_en),
    .ftw_out(ftw_out), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready), .gen_en(gen_en),
    .dac_tick(dac_tick), .seg_idx(seg_idx), .busy(busy), .done(done)
`ifdef WSEQ_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: phase 0 idle, 1 load, 2 run, 3 finish; segment ends after max(dur,1) ticks seen in run
  int m_cyc, m_phase, m_seen, m_need;
  bit m_ok = 0, m_last;
  logic [ADDR_W-1:0] m_idx;
  logic [FTW_W-1:0] m_ftw;
  logic [DUR_W-1:0] m_dur;
  logic [FTW_W-1:0] t_ftw [DEPTH];
  logic [DUR_W-1:0] t_dur [DEPTH];
  bit t_last [DEPTH];
  task automatic m_load(input int i);
    m_idx = ADDR_W'(i);
    m_ftw = t_ftw[i];
    m_dur = t_dur[i];
    m_last = t_last[i];
    m_phase = 1;
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0; m_phase = 0; m_idx = 0; m_ftw = 0; m_ok = 1;
`ifdef WSEQ_IRQ_EN
      m_irq = 0;
`endif
    end else begin
      bit tk;
      tk = (m_cyc % TICK) == TICK - 1;
`ifdef WSEQ_IRQ_EN
      if (m_phase == 3) m_irq = 1; else if (irq_clr) m_irq = 0;
`endif
      case (m_phase)
        0: if (start && !stop) m_load(0);
        1: if (stop) m_phase = 0;
           else if (ftw_ready) begin
             m_phase = 2; m_seen = 0; m_need = (m_dur == 0) ? 1 : int'(m_dur);
           end
        2: if (stop) m_phase = 0;
           else if (tk) begin
             m_seen++;
             if (m_seen >= m_need) begin
               if (m_last || int'(m_idx) == DEPTH - 1) begin
                 if (loop_en) m_load(0); else m_phase = 3;
               end else m_load(int'(m_idx) + 1);
             end
           end
        default: m_phase = 0;
      endcase
      if (cfg_we) begin
        t_ftw[cfg_addr] = cfg_ftw; t_dur[cfg_addr] = cfg_dur; t_last[cfg_addr] = cfg_last;
      end
      m_cyc++;
    end
  end
  always @(negedge clk) if (m_ok) begin
    chk("dac_tick", dac_tick, (m_cyc % TICK) == TICK - 1);
    chk("ftw_valid", ftw_valid, m_phase == 1);
    chk("gen_en", gen_en, m_phase == 2);
    chk("busy", busy, m_phase == 1 || m_phase == 2);
    chk("done", done, m_phase == 3);
    chk("seg_idx", seg_idx, m_idx);
    chk("ftw_out", ftw_out, m_ftw);
`ifdef WSEQ_IRQ_EN
    chk("irq", irq, m_irq);
`endif
  end
  logic [FTW_W-1:0] xq[$];
  int iq[$], vq[$];
  int ndone, ngen;
  task automatic wr(input int a, input logic [FTW_W-1:0] f, input int d, input bit l);
    @(negedge clk);
    cfg_we = 1; cfg_addr = ADDR_W'(a); cfg_ftw = f; cfg_dur = DUR_W'(d); cfg_last = l;
    @(negedge clk);
    cfg_we = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask
  // ready rises once ftw_valid has been seen for more than rdly cycles
  task automatic run(input int rdly, input int want);
    bit fin;
    int vcnt;
    logic [FTW_W-1:0] vfirst;
    xq.delete(); iq.delete(); vq.delete();
    ndone = 0; ngen = 0; vcnt = 0; fin = 0; vfirst = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (ftw_valid) vcnt++; else vcnt = 0;
      if (vcnt == 1) vfirst = ftw_out;
      if (vcnt > 1) chk("ftw_hold", ftw_out, vfirst);
      ftw_ready = ftw_valid && vcnt > rdly;
      if (ftw_valid && ftw_ready) begin
        xq.push_back(ftw_out); iq.push_back(int'(seg_idx)); vq.push_back(vcnt);
      end
      if (gen_en) ngen++;
      if (done) begin ndone++; fin = 1; end
      if (want > 0 && xq.size() >= want) fin = 1;
`ifdef WSEQ_IRQ_EN
      irq_clr = done && clr_on_done;
`endif
      @(negedge clk);
    end
    ftw_ready = 0;
`ifdef WSEQ_IRQ_EN
    irq_clr = 0;
`endif
    if (!fin) chk("run_timeout", 0, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_busy", busy, 0); chk("rst_valid", ftw_valid, 0); chk("rst_gen", gen_en, 0);
    chk("rst_done", done, 0); chk("rst_ftw", ftw_out, 0); chk("rst_idx", seg_idx, 0);
    repeat (16) @(negedge clk);
    chk("tick_pre", dac_tick, 0);
    @(negedge clk); chk("tick_first", dac_tick, 1);
    @(negedge clk); chk("tick_after", dac_tick, 0);
    repeat (17) @(negedge clk); chk("tick_period", dac_tick, 1);
    wr(0, 16'h0100, 2, 0);
    wr(1, 16'h0200, 3, 1);
    pulse_start();
    run(0, 0);
    chk("p1_nxfer", xq.size(), 2); chk("p1_ftw0", xq[0], 16'h0100); chk("p1_ftw1", xq[1], 16'h0200);
    chk("p1_done", ndone, 1); chk("p1_gen_len", ngen >= 56 && ngen <= 90, 1); chk("p1_busy", busy, 0);
`ifdef WSEQ_IRQ_EN
    chk("irq_set", irq, 1);
    irq_clr = 1; @(negedge clk); irq_clr = 0;
    chk("irq_clr", irq, 0);
`endif
    loop_en = 1;
    pulse_start();
    run(3, 5);
    chk("lp_nxfer", xq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("lp_idx", iq[i], i % 2);
      chk("lp_vlen", vq[i], 4);
      chk("lp_ftw", xq[i], (i % 2) ? 16'h0200 : 16'h0100);
    end
    chk("lp_nodone", ndone, 0);
    stop = 1; @(negedge clk); stop = 0;
    chk("stop_busy", busy, 0); chk("stop_gen", gen_en, 0); chk("stop_valid", ftw_valid, 0);
    loop_en = 0;
    wr(0, 16'h0300, 0, 1);
    pulse_start();
    run(0, 0);
    chk("z_nxfer", xq.size(), 1); chk("z_done", ndone, 1); chk("z_gen_len", ngen >= 1 && ngen <= 18, 1);
    @(negedge clk); start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    chk("ss_busy", busy, 0); chk("ss_valid", ftw_valid, 0);
    wr(0, 16'h0100, 2, 0);
    pulse_start();
    begin
      bit got;
      got = 0;
      for (int c = 0; c < 50 && !got; c++) begin
        ftw_ready = ftw_valid;
        @(negedge clk);
        got = gen_en;
      end
      ftw_ready = 0;
      chk("rs_reach_run", got, 1);
    end
    pulse_start();
    chk("rs_idx", seg_idx, 0); chk("rs_gen", gen_en, 1); chk("rs_valid", ftw_valid, 0);
`ifdef WSEQ_IRQ_EN
    irq_clr = 1; @(negedge clk); irq_clr = 0;
    chk("irq_pre", irq, 0);
    clr_on_done = 1;
`endif
    run(0, 0);
    chk("rs_nxfer", xq.size(), 1); chk("rs_ftw", xq[0], 16'h0200); chk("rs_done", ndone, 1);
`ifdef WSEQ_IRQ_EN
    chk("irq_set_wins", irq, 1);
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
